// File: rtl/mips_pkg.sv
// mips_pkg: shared definitions for the MIPS pipeline.
//   - opcode constants decoded by the issue stage
//   - R-type func constants shared with the ALU
//   - issue_bundle_t: the registered ID/EX bundle
//   - rtype_supported(): R-type funcs the ALU implements
package mips_pkg;

    localparam logic [5:0] OP_R     = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [5:0] FN_SLL  = 6'b000000;
    localparam logic [5:0] FN_SRL  = 6'b000010;
    localparam logic [5:0] FN_SRA  = 6'b000011;
    localparam logic [5:0] FN_SLLV = 6'b000100;
    localparam logic [5:0] FN_SRLV = 6'b000110;
    localparam logic [5:0] FN_SRAV = 6'b000111;
    localparam logic [5:0] FN_ADD  = 6'b100000;
    localparam logic [5:0] FN_ADDU = 6'b100001;
    localparam logic [5:0] FN_SUB  = 6'b100010;
    localparam logic [5:0] FN_SUBU = 6'b100011;
    localparam logic [5:0] FN_AND  = 6'b100100;
    localparam logic [5:0] FN_OR   = 6'b100101;
    localparam logic [5:0] FN_XOR  = 6'b100110;
    localparam logic [5:0] FN_NOR  = 6'b100111;
    localparam logic [5:0] FN_SLT  = 6'b101010;
    localparam logic [5:0] FN_SLTU = 6'b101011;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] first;
        logic [31:0] second;
        logic [5:0]  func;
        logic [5:0]  opcode;
        logic [4:0]  sa;
        logic [4:0]  rd;
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
        logic [31:0] store_data;
        logic        branch;
        logic        jump;
        logic [31:0] target;
        logic        illegal;
    } issue_bundle_t;

    function automatic logic rtype_supported(input logic [5:0] func);
        case (func)
            FN_SLL, FN_SRL, FN_SRA, FN_SLLV, FN_SRLV, FN_SRAV,
            FN_ADD, FN_ADDU, FN_SUB, FN_SUBU,
            FN_AND, FN_OR, FN_XOR, FN_NOR,
            FN_SLT, FN_SLTU: return 1'b1;
            default:         return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/reg_file.sv
// reg_file: 32-bit register file, two combinational read ports and one
// synchronous write port. r0 reads as zero and ignores writes. A read of the
// register being written this cycle returns the write data (write-through).
//   clk, rst         clock, asynchronous active-high reset (clears all regs)
//   rs_addr/rs_data  read port A
//   rt_addr/rt_data  read port B
//   wb_en/wb_addr/wb_data  write port
module reg_file #(
    parameter int DEPTH = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  rs_addr,
    output logic [31:0] rs_data,
    input  logic [4:0]  rt_addr,
    output logic [31:0] rt_data,
    input  logic        wb_en,
    input  logic [4:0]  wb_addr,
    input  logic [31:0] wb_data
);

    logic [31:0] regs [DEPTH];
    logic        wb_live;

    assign wb_live = wb_en && (wb_addr != 5'd0);

    // NOTE: this array is reset on purpose (architectural state must start at
    // zero), which forces flops rather than a RAM macro; most memories should
    // not be reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) regs[i] <= 32'd0;
        end else if (wb_live) begin
            regs[wb_addr] <= wb_data;
        end
    end

    assign rs_data = (rs_addr == 5'd0)                ? 32'd0   :
                     (wb_live && wb_addr == rs_addr)  ? wb_data : regs[rs_addr];
    assign rt_data = (rt_addr == 5'd0)                ? 32'd0   :
                     (wb_live && wb_addr == rt_addr)  ? wb_data : regs[rt_addr];

endmodule

// File: rtl/id_issue_stage.sv
// id_issue_stage: decode/operand-issue stage. Decodes in_instr, reads the
// register file, builds the ALU operands and control bits, and registers them
// into the ID/EX boundary with a valid/ready handshake.
//   clk, rst                      clock, asynchronous active-high reset
//   in_valid/in_ready/in_instr/in_pc  instruction input handshake
//   flush                         discard the instruction presented at input
//   wb_en/wb_addr/wb_data         register-file write-back port
//   out_valid/out_ready           issued bundle handshake
//   out_first..out_illegal, out_pc  registered issue bundle
module id_issue_stage
    import mips_pkg::*;
#(
    parameter int          RF_DEPTH = 32,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_instr,
    input  logic [31:0] in_pc,
    input  logic        flush,
    input  logic        wb_en,
    input  logic [4:0]  wb_addr,
    input  logic [31:0] wb_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_first,
    output logic [31:0] out_second,
    output logic [5:0]  out_func,
    output logic [5:0]  out_opcode,
    output logic [4:0]  out_sa,
    output logic [4:0]  out_rd,
    output logic        out_reg_write,
    output logic        out_mem_read,
    output logic        out_mem_write,
    output logic [31:0] out_store_data,
    output logic        out_branch,
    output logic        out_jump,
    output logic [31:0] out_target,
    output logic        out_illegal,
    output logic [31:0] out_pc
);

    logic [4:0]    rs_addr, rt_addr;
    logic [31:0]   rs_val, rt_val;
    logic [31:0]   imm_sext, pc_plus4;
    logic          reads_rt;
    logic          hazard, load_en, issue;
    issue_bundle_t dec, q, idle;

    assign rs_addr  = in_instr[25:21];
    assign rt_addr  = in_instr[20:16];
    assign imm_sext = {{16{in_instr[15]}}, in_instr[15:0]};
    assign pc_plus4 = in_pc + 32'd4;

    reg_file #(.DEPTH(RF_DEPTH)) u_reg_file (
        .clk     (clk),
        .rst     (rst),
        .rs_addr (rs_addr),
        .rs_data (rs_val),
        .rt_addr (rt_addr),
        .rt_data (rt_val),
        .wb_en   (wb_en),
        .wb_addr (wb_addr),
        .wb_data (wb_data)
    );

    // Bundle loaded on reset and for bubbles: everything zero, pc parked.
    always_comb begin
        idle    = '0;
        idle.pc = RESET_PC;
    end

    always_comb begin
        // NOTE: every field gets a default before the case, so no path leaves
        // a variable unassigned and no latch is inferred.
        dec        = '0;
        reads_rt   = 1'b0;
        dec.pc     = in_pc;
        dec.func   = in_instr[5:0];
        dec.opcode = in_instr[31:26];
        dec.sa     = in_instr[10:6];

        case (in_instr[31:26])
            OP_R: begin
                dec.first     = rs_val;
                dec.second    = rt_val;
                dec.rd        = in_instr[15:11];
                dec.reg_write = 1'b1;
                dec.illegal   = !rtype_supported(in_instr[5:0]);
                reads_rt      = 1'b1;
            end
            OP_ADDI, OP_ADDIU, OP_ANDI, OP_ORI, OP_XORI: begin
                dec.first     = rs_val;
                dec.second    = imm_sext;
                dec.rd        = rt_addr;
                dec.reg_write = 1'b1;
            end
            OP_LW: begin
                dec.first     = rs_val;
                dec.second    = imm_sext;
                dec.rd        = rt_addr;
                dec.reg_write = 1'b1;
                dec.mem_read  = 1'b1;
            end
            OP_SW: begin
                dec.first      = rs_val;
                dec.second     = imm_sext;
                dec.store_data = rt_val;
                dec.mem_write  = 1'b1;
                reads_rt       = 1'b1;
            end
            OP_BEQ, OP_BNE: begin
                dec.first  = rs_val;
                dec.second = rt_val;
                dec.branch = 1'b1;
                dec.target = pc_plus4 + {imm_sext[29:0], 2'b00};
                reads_rt   = 1'b1;
            end
            OP_J: begin
                dec.jump   = 1'b1;
                dec.target = {pc_plus4[31:28], in_instr[25:0], 2'b00};
            end
            OP_JAL: begin
                dec.jump       = 1'b1;
                dec.target     = {pc_plus4[31:28], in_instr[25:0], 2'b00};
                dec.rd         = 5'd31;
                dec.reg_write  = 1'b1;
                dec.store_data = pc_plus4;
            end
            default: begin
                dec.first   = rs_val;
                dec.second  = rt_val;
                dec.illegal = 1'b1;
            end
        endcase

        // Illegal instructions still flow down the pipe but must not change
        // architectural state.
        if (dec.illegal) begin
            dec.rd        = 5'd0;
            dec.reg_write = 1'b0;
        end
        if (dec.rd == 5'd0) dec.reg_write = 1'b0;
    end

    // A load in EX produces its value too late to be read here; hold the
    // consumer back one cycle.
    assign hazard  = out_valid && q.mem_read && (q.rd != 5'd0) &&
                     ((q.rd == rs_addr) || (reads_rt && (q.rd == rt_addr)));
    assign load_en = !out_valid || out_ready;
    assign in_ready = !rst && (flush || (load_en && !hazard));
    assign issue    = in_valid && !flush && !hazard;

    // NOTE: state updates use non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            q         <= idle;
        end else if (load_en) begin
            out_valid <= issue;
            q         <= issue ? dec : idle;
        end
    end

    assign out_first      = q.first;
    assign out_second     = q.second;
    assign out_func       = q.func;
    assign out_opcode     = q.opcode;
    assign out_sa         = q.sa;
    assign out_rd         = q.rd;
    assign out_reg_write  = q.reg_write;
    assign out_mem_read   = q.mem_read;
    assign out_mem_write  = q.mem_write;
    assign out_store_data = q.store_data;
    assign out_branch     = q.branch;
    assign out_jump       = q.jump;
    assign out_target     = q.target;
    assign out_illegal    = q.illegal;
    assign out_pc         = q.pc;

endmodule

// File: tb/tb_id_issue_stage.sv
module tb_id_issue_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, flush, wb_en, out_valid, out_ready;
    logic [31:0] in_instr, in_pc, wb_data;
    logic [4:0]  wb_addr;
    logic [31:0] out_first, out_second, out_store_data, out_target, out_pc;
    logic [5:0]  out_func, out_opcode;
    logic [4:0]  out_sa, out_rd;
    logic        out_reg_write, out_mem_read, out_mem_write;
    logic        out_branch, out_jump, out_illegal;

    int errors = 0;
    int checks = 0;

    id_issue_stage #(.RF_DEPTH(32), .RESET_PC(32'h0)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_pc(in_pc), .flush(flush),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_first(out_first), .out_second(out_second),
        .out_func(out_func), .out_opcode(out_opcode), .out_sa(out_sa),
        .out_rd(out_rd), .out_reg_write(out_reg_write),
        .out_mem_read(out_mem_read), .out_mem_write(out_mem_write),
        .out_store_data(out_store_data), .out_branch(out_branch),
        .out_jump(out_jump), .out_target(out_target),
        .out_illegal(out_illegal), .out_pc(out_pc)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        valid_in;
        logic        wen;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic        valid;
        logic [31:0] first;
        logic [31:0] second;
        logic [5:0]  func;
        logic [5:0]  opcode;
        logic [4:0]  sa;
        logic [4:0]  rd;
        logic        rw;
        logic        mr;
        logic        mw;
        logic [31:0] store;
        logic        br;
        logic        jmp;
        logic [31:0] target;
        logic        ill;
    } vec_t;

    vec_t vq[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [31:0] instr, input logic [31:0] pc, input logic v);
        in_instr = instr;
        in_pc    = pc;
        in_valid = v;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_vec(input int i, input vec_t v);
        check($sformatf("v%0d valid", i),  {31'd0, out_valid},     {31'd0, v.valid});
        check($sformatf("v%0d first", i),  out_first,               v.first);
        check($sformatf("v%0d second", i), out_second,              v.second);
        check($sformatf("v%0d func", i),   {26'd0, out_func},      {26'd0, v.func});
        check($sformatf("v%0d opcode", i), {26'd0, out_opcode},    {26'd0, v.opcode});
        check($sformatf("v%0d sa", i),     {27'd0, out_sa},        {27'd0, v.sa});
        check($sformatf("v%0d rd", i),     {27'd0, out_rd},        {27'd0, v.rd});
        check($sformatf("v%0d ctrl", i),
              {26'd0, out_reg_write, out_mem_read, out_mem_write, out_branch, out_jump, out_illegal},
              {26'd0, v.rw, v.mr, v.mw, v.br, v.jmp, v.ill});
        check($sformatf("v%0d store", i),  out_store_data,          v.store);
        check($sformatf("v%0d target", i), out_target,              v.target);
    endtask

    initial begin
        // instr, pc, in_valid, wen, waddr, wdata | valid, first, second, func, opcode, sa, rd, rw, mr, mw, store, br, jmp, target, ill
        vq.push_back('{32'h00000000, 32'h0C, 1'b1, 1'b1, 5'd1, 32'd5,
                       1'b1, 32'd0, 32'd0, 6'h00, 6'h00, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b0});
        vq.push_back('{32'h2022FFFD, 32'h10, 1'b1, 1'b0, 5'd0, 32'd0,
                       1'b1, 32'd5, 32'hFFFFFFFD, 6'h3D, 6'h08, 5'd31, 5'd2, 1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b0});
        vq.push_back('{32'h00632020, 32'h14, 1'b1, 1'b1, 5'd3, 32'd7,
                       1'b1, 32'd7, 32'd7, 6'h20, 6'h00, 5'd0, 5'd4, 1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b0});
        vq.push_back('{32'hAC230008, 32'h18, 1'b1, 1'b0, 5'd0, 32'd0,
                       1'b1, 32'd5, 32'd8, 6'h08, 6'h2B, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 32'd7, 1'b0, 1'b0, 32'd0, 1'b0});
        vq.push_back('{32'h1023FFFE, 32'h40, 1'b1, 1'b0, 5'd0, 32'd0,
                       1'b1, 32'd5, 32'd7, 6'h3E, 6'h04, 5'd31, 5'd0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 32'h3C, 1'b0});
        vq.push_back('{32'h08000010, 32'h80, 1'b1, 1'b0, 5'd0, 32'd0,
                       1'b1, 32'd0, 32'd0, 6'h10, 6'h02, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 32'h40, 1'b0});
        vq.push_back('{32'hFC200000, 32'h84, 1'b1, 1'b0, 5'd0, 32'd0,
                       1'b1, 32'd5, 32'd0, 6'h00, 6'h3F, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b1});
        vq.push_back('{32'h00200008, 32'h88, 1'b1, 1'b0, 5'd0, 32'd0,
                       1'b1, 32'd5, 32'd0, 6'h08, 6'h00, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b1});
        vq.push_back('{32'h00632020, 32'h8C, 1'b0, 1'b0, 5'd0, 32'd0,
                       1'b0, 32'd0, 32'd0, 6'h00, 6'h00, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b0});
        vq.push_back('{32'h34678000, 32'h90, 1'b1, 1'b0, 5'd0, 32'd0,
                       1'b1, 32'd7, 32'hFFFF8000, 6'h00, 6'h0D, 5'd0, 5'd7, 1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b0});
        vq.push_back('{32'h20200001, 32'h94, 1'b1, 1'b0, 5'd0, 32'd0,
                       1'b1, 32'd5, 32'd1, 6'h01, 6'h08, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b0});

        rst = 1'b1;
        flush = 1'b0; wb_en = 1'b0; wb_addr = 5'd0; wb_data = 32'd0;
        out_ready = 1'b1;
        drive(32'd0, 32'd0, 1'b0);

        // Reset state
        tick(); tick();
        check("rst out_valid", {31'd0, out_valid}, 32'd0);
        check("rst in_ready", {31'd0, in_ready}, 32'd0);
        check("rst out_first", out_first, 32'd0);
        check("rst out_pc", out_pc, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("post-rst in_ready", {31'd0, in_ready}, 32'd1);

        // Table-driven single-cycle vectors
        for (int i = 0; i < vq.size(); i++) begin
            drive(vq[i].instr, vq[i].pc, vq[i].valid_in);
            wb_en = vq[i].wen; wb_addr = vq[i].waddr; wb_data = vq[i].wdata;
            tick();
            check_vec(i, vq[i]);
        end
        wb_en = 1'b0;

        // Load-use stall: lw r5,4(r0) then add r6,r5,r5
        drive(32'h8C050004, 32'hA0, 1'b1);
        tick();
        check("lw issued", {30'd0, out_valid, out_mem_read}, 32'd3);
        check("lw rd", {27'd0, out_rd}, 32'd5);
        drive(32'h00A53020, 32'hA4, 1'b1);
        #1;
        check("load-use in_ready", {31'd0, in_ready}, 32'd0);
        tick();
        check("load-use bubble", {30'd0, out_valid, out_mem_read}, 32'd0);
        check("after bubble in_ready", {31'd0, in_ready}, 32'd1);
        tick();
        check("add after stall valid", {31'd0, out_valid}, 32'd1);
        check("add after stall rd", {27'd0, out_rd}, 32'd6);

        // flush overrides the load-use stall
        drive(32'h8C050004, 32'hA8, 1'b1);
        tick();
        drive(32'h00A53020, 32'hAC, 1'b1);
        flush = 1'b1;
        #1;
        check("flush over hazard in_ready", {31'd0, in_ready}, 32'd1);
        tick();
        check("flush over hazard bubble", {31'd0, out_valid}, 32'd0);
        flush = 1'b0;

        // Back-pressure: sll r2,r2,2 held for 3 cycles
        drive(32'h00021080, 32'hB0, 1'b1);
        tick();
        check("sll sa", {27'd0, out_sa}, 32'd2);
        out_ready = 1'b0;
        drive(32'h00000000, 32'hB4, 1'b1);
        for (int k = 0; k < 3; k++) begin
            #1;
            check($sformatf("hold%0d in_ready", k), {31'd0, in_ready}, 32'd0);
            tick();
            check($sformatf("hold%0d bundle", k),
                  {out_valid, out_reg_write, out_rd, out_sa, out_func, out_pc[15:0]},
                  {1'b1, 1'b1, 5'd2, 5'd2, 6'h00, 16'h00B0});
        end
        out_ready = 1'b1;
        #1;
        check("release in_ready", {31'd0, in_ready}, 32'd1);
        tick();
        check("after hold next issued", {out_valid, out_sa, out_pc[15:0]}, {1'b1, 5'd0, 16'h00B4});

        // Flush a pending beq
        drive(32'h1023FFFE, 32'hC0, 1'b1);
        flush = 1'b1;
        #1;
        check("flush in_ready", {31'd0, in_ready}, 32'd1);
        tick();
        check("flushed beq", {30'd0, out_valid, out_branch}, 32'd0);
        flush = 1'b0;

        // Writes to r0 are ignored, also for write-through
        wb_en = 1'b1; wb_addr = 5'd0; wb_data = 32'h0000FFFF;
        drive(32'h20090001, 32'hC4, 1'b1);
        tick();
        check("r0 write-through", out_first, 32'd0);
        check("addi r9 rd", {27'd0, out_rd}, 32'd9);
        wb_en = 1'b0;
        tick();
        check("r0 after write", out_first, 32'd0);

        // jal at 0x100
        drive(32'h0C000010, 32'h100, 1'b1);
        tick();
        check("jal rd", {27'd0, out_rd}, 32'd31);
        check("jal store_data", out_store_data, 32'h104);
        check("jal jump/rw", {30'd0, out_jump, out_reg_write}, 32'd3);
        check("jal target", out_target, 32'h40);
        check("jal pc", out_pc, 32'h100);

        // Reset mid-stream clears outputs and registers
        drive(32'h00632020, 32'h110, 1'b1);
        tick();
        check("pre-reset add first", out_first, 32'd7);
        rst = 1'b1;
        #1;
        check("mid-rst out_valid", {31'd0, out_valid}, 32'd0);
        check("mid-rst outputs", {out_first[15:0], out_rd, out_func, out_reg_write}, 28'd0);
        check("mid-rst out_pc", out_pc, 32'h0);
        check("mid-rst in_ready", {31'd0, in_ready}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("post-mid-rst in_ready", {31'd0, in_ready}, 32'd1);
        tick();
        check("regs cleared", {out_valid, out_first[30:0]}, 32'h80000000);
        check("add rd after reset", {27'd0, out_rd}, 32'd4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
